// File: rtl/fpu_add_result_pack_pkg.sv
// Shared constants, types and helpers for the adder result-pack stage.
// Provides IEEE-754 single field widths, flag bit positions, the FIFO
// entry layout and the NaN-quieting packer.
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int FLAG_W = 5;

  localparam int FLG_INV  = 4;
  localparam int FLG_OVF  = 3;
  localparam int FLG_UNF  = 2;
  localparam int FLG_INX  = 1;
  localparam int FLG_ZERO = 0;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam int QNAN_BIT = 22;

  localparam int WORD_W  = 1 + EXP_W + MAN_W;
  localparam int ENTRY_W = WORD_W + FLAG_W;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [FLAG_W-1:0] flags;
  } res_entry_t;

  // Any NaN (max exponent, non-zero mantissa) leaves as a quiet NaN;
  // sign and remaining payload bits are kept.
  function automatic logic [WORD_W-1:0] pack_word(input logic s,
                                                  input logic [EXP_W-1:0] e,
                                                  input logic [MAN_W-1:0] m);
    logic [MAN_W-1:0] mq;
    mq = m;
    if (e == EXP_MAX && m != '0) mq[QNAN_BIT] = 1'b1;
    return {s, e, mq};
  endfunction

endpackage

// File: rtl/fpu_add_result_pack_if.sv
// Bus between the adder side / consumer and the result-pack stage.
//   issue_req/issue_gnt : operand launch handshake
//   Sz/Ez/Mz/in_flags   : adder result fields and exception flags
//   res_*               : valid/ready result stream (packed word + flags)
//   sticky_*            : accumulated exception flags and their clear
// slave is the result-pack stage, master is the environment driving it.
interface fpu_add_result_pack_if;
  import fpu_pkg::*;

  logic                issue_req;
  logic                issue_gnt;
  logic                Sz;
  logic [EXP_W-1:0]    Ez;
  logic [MAN_W-1:0]    Mz;
  logic [FLAG_W-1:0]   in_flags;
  logic                res_valid;
  logic                res_ready;
  logic [WORD_W-1:0]   res_data;
  logic [FLAG_W-1:0]   res_flags;
  logic [FLAG_W-2:0]   sticky_flags;
  logic                sticky_clr;

  modport master (
    output issue_req, Sz, Ez, Mz, in_flags, res_ready, sticky_clr,
    input  issue_gnt, res_valid, res_data, res_flags, sticky_flags
  );

  modport slave (
    input  issue_req, Sz, Ez, Mz, in_flags, res_ready, sticky_clr,
    output issue_gnt, res_valid, res_data, res_flags, sticky_flags
  );

endinterface

// File: rtl/fpu_add_result_pack_fifo.sv
// Generic circular FIFO, DEPTH entries of WIDTH bits (DEPTH power of two).
// Ports: clk, rst (async active-low), push/din write, pop read-advance,
// dout = head entry (registered storage, no write-to-read bypass),
// full, empty, count. The caller must not pop when empty nor push when
// full without a pop.
module fpu_res_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/fpu_add_result_pack.sv
// Result-pack stage behind the fixed-latency adder.
// Ports: clk, rst (async active-low), bus (slave side of
// fpu_add_result_pack_if). Launches are credit-gated so every operation
// already in the adder is guaranteed a FIFO slot when its result arrives
// ADD_LAT edges after the grant; results are packed (NaN quieted),
// buffered, and their exception flags accumulated into sticky_flags.
module fpu_add_result_pack
  import fpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ADD_LAT = 1
) (
  input logic clk,
  input logic rst,
  fpu_add_result_pack_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]      credit;
  logic [ADD_LAT-1:0] trk;
  logic               grant;
  logic               push;
  logic               push_en;
  logic               pop;
  logic               full;
  logic               empty;
  logic [CW-1:0]      count;
  logic [FLAG_W-2:0]  sticky;
  res_entry_t         wr_entry;
  res_entry_t         rd_entry;

  assign grant         = bus.issue_req & (credit != '0);
  assign bus.issue_gnt = grant;

  assign push = trk[ADD_LAT-1];
  assign pop  = !empty & bus.res_ready;
  // Credits make an unpopped full-FIFO push impossible; the guard keeps
  // the head intact should that ever be violated.
  assign push_en = push & (!full | pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit <= CW'(DEPTH);
    end else begin
      case ({grant, pop})
        2'b10:   credit <= credit - 1'b1;
        2'b01:   credit <= credit + 1'b1;
        default: credit <= credit;
      endcase
    end
  end

  generate
    if (ADD_LAT == 1) begin : g_trk1
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) trk <= '0;
        else      trk <= grant;
      end
    end else begin : g_trkn
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) trk <= '0;
        else      trk <= {trk[ADD_LAT-2:0], grant};
      end
    end
  endgenerate

  // Clear takes effect before the same-edge push's flags are merged in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sticky <= '0;
    end else if (push) begin
      sticky <= (bus.sticky_clr ? '0 : sticky) | bus.in_flags[FLG_INV:FLG_INX];
    end else if (bus.sticky_clr) begin
      sticky <= '0;
    end
  end

  assign wr_entry.data  = pack_word(bus.Sz, bus.Ez, bus.Mz);
  assign wr_entry.flags = bus.in_flags;

  fpu_res_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_en),
    .pop   (pop),
    .din   (wr_entry),
    .dout  (rd_entry),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign bus.res_valid    = (count != '0);
  assign bus.res_data     = rd_entry.data;
  assign bus.res_flags    = rd_entry.flags;
  assign bus.sticky_flags = sticky;

endmodule

// File: tb/tb_fpu_add_result_pack.sv
module tb_fpu_add_result_pack;

  localparam int DEPTH   = 4;
  localparam int ADD_LAT = 2;

  logic clk;
  logic rst;

  fpu_add_result_pack_if bus ();

  fpu_add_result_pack #(.DEPTH(DEPTH), .ADD_LAT(ADD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic [4:0]  f;
    int          due;
  } op_t;

  op_t         inflight[$];
  op_t         op_src[$];
  logic [36:0] efifo[$];
  logic [3:0]  msticky;
  int          cyc;
  logic        cur_req, cur_ready, cur_clr, push_now;
  logic        exp_gnt, exp_valid;
  logic [31:0] exp_data;
  logic [4:0]  exp_flags;

  function automatic logic [31:0] ref_pack(input op_t o);
    logic [31:0] w;
    w = {o.s, o.e, o.m};
    if (o.e == 8'd255 && o.m != 23'd0) w = w | 32'h0040_0000;
    return w;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.s = 1'($urandom);
    o.e = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
    o.m = ($urandom_range(0, 2) == 0) ? 23'd0 : 23'($urandom);
    o.f = 5'($urandom);
    o.due = 0;
    return o;
  endfunction

  function automatic op_t mk_op(input logic s, input logic [7:0] e,
                                input logic [22:0] m, input logic [4:0] f);
    op_t o;
    o.s = s; o.e = e; o.m = m; o.f = f; o.due = 0;
    return o;
  endfunction

  task automatic model_reset();
    inflight.delete();
    efifo.delete();
    msticky = '0;
  endtask

  // Drive one cycle's inputs mid-cycle and compute what the DUT must show.
  task automatic setup(input logic req, input logic ready, input logic clr);
    op_t g;
    int  credit;
    @(negedge clk);
    cur_req = req; cur_ready = ready; cur_clr = clr;
    push_now = (inflight.size() > 0) && (inflight[0].due == cyc);
    g = push_now ? inflight[0] : rand_op();
    bus.Sz = g.s; bus.Ez = g.e; bus.Mz = g.m; bus.in_flags = g.f;
    bus.issue_req = req; bus.res_ready = ready; bus.sticky_clr = clr;
    #1;
    credit = DEPTH - inflight.size() - efifo.size();
    exp_gnt = req && (credit > 0);
    exp_valid = (efifo.size() > 0);
    if (exp_valid) {exp_data, exp_flags} = efifo[0];
  endtask

  task automatic advance();
    op_t o;
    @(posedge clk);
    if (exp_valid && cur_ready) void'(efifo.pop_front());
    if (push_now) begin
      o = inflight.pop_front();
      efifo.push_back({ref_pack(o), o.f});
      msticky = (cur_clr ? 4'd0 : msticky) | o.f[4:1];
    end else if (cur_clr) begin
      msticky = '0;
    end
    if (exp_gnt) begin
      o = (op_src.size() > 0) ? op_src.pop_front() : rand_op();
      o.due = cyc + ADD_LAT;
      inflight.push_back(o);
    end
    cyc++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((inflight.size() > 0 || efifo.size() > 0) && n < 40) begin
      setup(1'b0, 1'b1, 1'b0);
      advance();
      n++;
    end
    checks++;
    if (inflight.size() > 0 || efifo.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d left exp 0", inflight.size() + efifo.size());
    end
  endtask

  // FIFO must never take a push while full unless it pops on the same edge.
  always @(posedge clk) begin
    if (rst && dut.push && dut.full && !dut.pop) begin
      errors++;
      $display("FAIL fifo_overflow got push_at_full exp none");
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    bus.issue_req = 0; bus.res_ready = 0; bus.sticky_clr = 0;
    bus.Sz = 0; bus.Ez = '0; bus.Mz = '0; bus.in_flags = '0;
    model_reset();
    cyc = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.res_valid, bus.res_data, bus.res_flags, bus.sticky_flags} !== 42'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%0b d=%h f=%h s=%h exp 0", bus.res_valid,
               bus.res_data, bus.res_flags, bus.sticky_flags);
    end
    rst = 1'b1;
  endtask

  task automatic test_normal();
    int t, seen;
    drain();
    setup(1'b0, 1'b1, 1'b1); advance();
    op_src.push_back(mk_op(1'b0, 8'h82, 23'h1C0000, 5'b00000));
    t = cyc;
    seen = -1;
    setup(1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.issue_gnt !== 1'b1) begin
      errors++; $display("FAIL normal_gnt got %0b exp 1", bus.issue_gnt);
    end
    advance();
    for (int i = 0; i < ADD_LAT + 2; i++) begin
      setup(1'b0, 1'b1, 1'b0);
      checks++;
      if (bus.res_valid !== exp_valid) begin
        errors++; $display("FAIL normal_valid got %0b exp %0b", bus.res_valid, exp_valid);
      end
      if (bus.res_valid === 1'b1 && seen < 0) begin
        seen = cyc;
        checks++;
        if ({bus.res_data, bus.res_flags} !== {32'h411C0000, 5'd0}) begin
          errors++; $display("FAIL normal_data got %h/%h exp 411c0000/00", bus.res_data, bus.res_flags);
        end
      end
      advance();
    end
    checks++;
    if (seen != t + ADD_LAT + 1) begin
      errors++; $display("FAIL normal_latency got %0d exp %0d", seen - t, ADD_LAT + 1);
    end
    checks++;
    if (bus.sticky_flags !== 4'd0) begin
      errors++; $display("FAIL normal_sticky got %b exp 0000", bus.sticky_flags);
    end
  endtask

  task automatic test_nan();
    drain();
    setup(1'b0, 1'b1, 1'b1); advance();
    op_src.push_back(mk_op(1'b0, 8'hFF, 23'h000208, 5'b10000));
    op_src.push_back(mk_op(1'b0, 8'hFF, 23'h000000, 5'b01000));
    setup(1'b1, 1'b0, 1'b0); advance();
    setup(1'b1, 1'b0, 1'b0); advance();
    repeat (ADD_LAT + 2) begin setup(1'b0, 1'b0, 1'b0); advance(); end
    setup(1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h7FC00208) begin
      errors++; $display("FAIL nan_quiet got v=%0b %h exp 7fc00208", bus.res_valid, bus.res_data);
    end
    advance();
    setup(1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h7F800000) begin
      errors++; $display("FAIL nan_inf got v=%0b %h exp 7f800000", bus.res_valid, bus.res_data);
    end
    checks++;
    if (bus.sticky_flags !== 4'b1100) begin
      errors++; $display("FAIL nan_sticky got %b exp 1100", bus.sticky_flags);
    end
    advance();
  endtask

  task automatic test_backpressure();
    int grants;
    logic [31:0] held;
    drain();
    grants = 0;
    held = '0;
    for (int i = 0; i < 10; i++) begin
      setup(1'b1, 1'b0, 1'b0);
      checks++;
      if (bus.issue_gnt !== exp_gnt || bus.res_valid !== exp_valid) begin
        errors++; $display("FAIL bp_cycle got g=%0b v=%0b exp g=%0b v=%0b",
                           bus.issue_gnt, bus.res_valid, exp_gnt, exp_valid);
      end
      if (bus.issue_gnt === 1'b1) grants++;
      if (exp_valid) begin
        if (held == '0) held = exp_data;
        checks++;
        if (bus.res_data !== held) begin
          errors++; $display("FAIL bp_stable got %h exp %h", bus.res_data, held);
        end
      end
      advance();
    end
    checks++;
    if (grants != DEPTH) begin
      errors++; $display("FAIL bp_grants got %0d exp %0d", grants, DEPTH);
    end
    setup(1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.issue_gnt !== 1'b0) begin
      errors++; $display("FAIL bp_pop_gnt got %0b exp 0", bus.issue_gnt);
    end
    advance();
    setup(1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.issue_gnt !== 1'b1) begin
      errors++; $display("FAIL bp_regnt got %0b exp 1", bus.issue_gnt);
    end
    advance();
    setup(1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.issue_gnt !== 1'b0) begin
      errors++; $display("FAIL bp_regnt_once got %0b exp 0", bus.issue_gnt);
    end
    advance();
  endtask

  task automatic test_sticky();
    drain();
    setup(1'b0, 1'b1, 1'b1); advance();
    op_src.push_back(mk_op(1'b0, 8'h10, 23'h1, 5'b00010));
    op_src.push_back(mk_op(1'b1, 8'h20, 23'h2, 5'b01000));
    setup(1'b1, 1'b1, 1'b0); advance();
    setup(1'b1, 1'b1, 1'b0); advance();
    repeat (ADD_LAT + 1) begin setup(1'b0, 1'b1, 1'b0); advance(); end
    setup(1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.sticky_flags !== 4'b0101) begin
      errors++; $display("FAIL sticky_or got %b exp 0101", bus.sticky_flags);
    end
    advance();
    op_src.push_back(mk_op(1'b0, 8'h30, 23'h3, 5'b10000));
    setup(1'b1, 1'b1, 1'b0); advance();
    repeat (ADD_LAT - 1) begin setup(1'b0, 1'b1, 1'b0); advance(); end
    setup(1'b0, 1'b1, 1'b1); advance();
    setup(1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.sticky_flags !== 4'b1000) begin
      errors++; $display("FAIL sticky_clr_push got %b exp 1000", bus.sticky_flags);
    end
    advance();
    setup(1'b0, 1'b1, 1'b1); advance();
    setup(1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.sticky_flags !== 4'b0000) begin
      errors++; $display("FAIL sticky_clr got %b exp 0000", bus.sticky_flags);
    end
    advance();
  endtask

  // Full model comparison every cycle; req/ready/clr either fixed or random.
  task automatic run_checked(input int n, input bit rnd, input string name);
    logic rq, rd, cl;
    for (int i = 0; i < n; i++) begin
      rq = rnd ? 1'($urandom) : 1'b1;
      rd = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      cl = rnd ? ($urandom_range(0, 15) == 0) : 1'b0;
      setup(rq, rd, cl);
      checks++;
      if (bus.issue_gnt !== exp_gnt || bus.res_valid !== exp_valid ||
          bus.sticky_flags !== msticky ||
          (exp_valid && {bus.res_data, bus.res_flags} !== {exp_data, exp_flags})) begin
        errors++;
        $display("FAIL %s cyc %0d got g=%0b v=%0b d=%h f=%h s=%h exp g=%0b v=%0b d=%h f=%h s=%h",
                 name, cyc, bus.issue_gnt, bus.res_valid, bus.res_data, bus.res_flags,
                 bus.sticky_flags, exp_gnt, exp_valid, exp_data, exp_flags, msticky);
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    drain();
    repeat (DEPTH + ADD_LAT + 2) begin setup(1'b1, 1'b0, 1'b0); advance(); end
    checks++;
    if (efifo.size() != DEPTH || bus.issue_gnt !== 1'b0) begin
      errors++; $display("FAIL stream_fill got %0d/%0b exp %0d/0", efifo.size(), bus.issue_gnt, DEPTH);
    end
    run_checked(40, 1'b0, "stream");
  endtask

  task automatic test_random();
    drain();
    run_checked(300, 1'b1, "random");
  endtask

  task automatic test_reset_mid();
    drain();
    setup(1'b0, 1'b1, 1'b1); advance();
    op_src.push_back(mk_op(1'b0, 8'h40, 23'h4, 5'b11110));
    repeat (3) begin setup(1'b1, 1'b0, 1'b0); advance(); end
    setup(1'b0, 1'b0, 1'b0);
    checks++;
    if (efifo.size() != 1 || inflight.size() != 2 || bus.res_valid !== 1'b1 ||
        bus.sticky_flags !== 4'b1111) begin
      errors++; $display("FAIL rstmid_pre got v=%0b s=%b exp v=1 s=1111", bus.res_valid, bus.sticky_flags);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.sticky_flags !== 4'd0) begin
      errors++; $display("FAIL rstmid_async got v=%0b s=%b exp 0/0000", bus.res_valid, bus.sticky_flags);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      setup(1'b1, 1'b0, 1'b0);
      checks++;
      if (bus.issue_gnt !== 1'b1) begin
        errors++; $display("FAIL rstmid_gnt%0d got %0b exp 1", i, bus.issue_gnt);
      end
      advance();
    end
    run_checked(12, 1'b0, "rstmid_after");
  endtask

  initial begin
    test_reset();
    test_normal();
    test_nan();
    test_backpressure();
    test_sticky();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1);
  end

endmodule
